// File: rtl/and_gate_test_sequencer_if.sv
// Signal bundle between the AND-gate self-test sequencer, the gate under test and the status side.
// The slave modport is the sequencer's view; the master modport is the gate/control side.
interface and_gate_test_sequencer_if;
  logic       start;
  logic       abort;
  logic       e_in;
  logic       f_in;
  logic       g_in;
  logic       a_out;
  logic       b_out;
  logic       c_out;
  logic       d_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_cnt;
  logic       fail_valid;
  logic [3:0] fail_vec;
  logic [2:0] fail_efg;

  modport slave (
    input  start, abort, e_in, f_in, g_in,
    output a_out, b_out, c_out, d_out, busy, done, pass,
           err_cnt, fail_valid, fail_vec, fail_efg
  );

  modport master (
    output start, abort, e_in, f_in, g_in,
    input  a_out, b_out, c_out, d_out, busy, done, pass,
           err_cnt, fail_valid, fail_vec, fail_efg
  );
endinterface

// File: rtl/and_gate_test_sequencer.sv
// Clocked self-test sweep for a four-input AND gate: drives all 16 vectors, lets each settle,
// checks e/f/g against a&b, c&d, a&b&c&d and records the error count and the first failure.
module and_gate_test_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter bit STOP_ON_FAIL  = 1'b0
) (
  input logic                      clk,
  input logic                      rst_n,
  and_gate_test_sequencer_if.slave bus
);
  localparam int SCNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        vec_reg, vec_next;
  logic [SCNT_W-1:0] scnt_reg, scnt_next;
  logic [4:0]        err_cnt_reg, err_cnt_next;
  logic              fail_valid_reg, fail_valid_next;
  logic [3:0]        fail_vec_reg, fail_vec_next;
  logic [2:0]        fail_efg_reg, fail_efg_next;

  logic [2:0] efg_obs;
  logic [2:0] efg_exp;
  logic [2:0] efg_diff;
  logic       mismatch;

  assign efg_obs = {bus.e_in, bus.f_in, bus.g_in};
  assign efg_exp = {vec_reg[3] & vec_reg[2], vec_reg[1] & vec_reg[0], &vec_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_diff
      assign efg_diff[gi] = efg_obs[gi] ^ efg_exp[gi];
    end
  endgenerate

  assign mismatch = |efg_diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      vec_reg        <= '0;
      scnt_reg       <= '0;
      err_cnt_reg    <= '0;
      fail_valid_reg <= 1'b0;
      fail_vec_reg   <= '0;
      fail_efg_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      vec_reg        <= vec_next;
      scnt_reg       <= scnt_next;
      err_cnt_reg    <= err_cnt_next;
      fail_valid_reg <= fail_valid_next;
      fail_vec_reg   <= fail_vec_next;
      fail_efg_reg   <= fail_efg_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    vec_next        = vec_reg;
    scnt_next       = scnt_reg;
    err_cnt_next    = err_cnt_reg;
    fail_valid_next = fail_valid_reg;
    fail_vec_next   = fail_vec_reg;
    fail_efg_next   = fail_efg_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next      = SETTLE;
          vec_next        = '0;
          scnt_next       = '0;
          err_cnt_next    = '0;
          fail_valid_next = 1'b0;
          fail_vec_next   = '0;
          fail_efg_next   = '0;
        end
      end
      SETTLE: begin
        // scnt never passes SETTLE_CYCLES, so the free increment cannot wrap.
        scnt_next = scnt_reg + 1'b1;
        if (scnt_reg == SCNT_LAST) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_cnt_next = err_cnt_reg + 5'd1;
          if (!fail_valid_reg) begin
            fail_valid_next = 1'b1;
            fail_vec_next   = vec_reg;
            fail_efg_next   = efg_obs;
          end
        end
        if (vec_reg == 4'hF || (STOP_ON_FAIL && mismatch)) begin
          state_next = DONE;
        end else begin
          state_next = SETTLE;
          vec_next   = vec_reg + 4'd1;
          scnt_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort beats start and discards an in-flight check, but keeps earlier results visible.
    if (bus.abort) begin
      state_next      = IDLE;
      vec_next        = '0;
      scnt_next       = '0;
      err_cnt_next    = err_cnt_reg;
      fail_valid_next = fail_valid_reg;
      fail_vec_next   = fail_vec_reg;
      fail_efg_next   = fail_efg_reg;
    end
  end

  assign bus.a_out      = vec_reg[3];
  assign bus.b_out      = vec_reg[2];
  assign bus.c_out      = vec_reg[1];
  assign bus.d_out      = vec_reg[0];
  assign bus.busy       = (state_reg == SETTLE) || (state_reg == CHECK);
  assign bus.done       = (state_reg == DONE);
  assign bus.pass       = (state_reg == DONE) && (err_cnt_reg == 5'd0);
  assign bus.err_cnt    = err_cnt_reg;
  assign bus.fail_valid = fail_valid_reg;
  assign bus.fail_vec   = fail_vec_reg;
  assign bus.fail_efg   = fail_efg_reg;
endmodule

// File: tb/tb_and_gate_test_sequencer.sv
// Bench for and_gate_test_sequencer: a faultable gate model feeds two sequencers
// (sweep-all and stop-on-fail), and results are compared against a vector-by-vector reference.
module tb_and_gate_test_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sa0 = 3'b000;   // stuck-at-0 mask, bit order {e,f,g}
  logic [2:0] sa1 = 3'b000;   // stuck-at-1 mask, bit order {e,f,g}
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  and_gate_test_sequencer_if bus0 ();
  and_gate_test_sequencer_if bus1 ();

  assign bus0.e_in = ((bus0.a_out & bus0.b_out) & ~sa0[2]) | sa1[2];
  assign bus0.f_in = ((bus0.c_out & bus0.d_out) & ~sa0[1]) | sa1[1];
  assign bus0.g_in = ((bus0.a_out & bus0.b_out & bus0.c_out & bus0.d_out) & ~sa0[0]) | sa1[0];
  assign bus1.e_in = ((bus1.a_out & bus1.b_out) & ~sa0[2]) | sa1[2];
  assign bus1.f_in = ((bus1.c_out & bus1.d_out) & ~sa0[1]) | sa1[1];
  assign bus1.g_in = ((bus1.a_out & bus1.b_out & bus1.c_out & bus1.d_out) & ~sa0[0]) | sa1[0];

  and_gate_test_sequencer #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  and_gate_test_sequencer #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  logic [3:0]  vec0, vec1;
  logic [19:0] all0, all1;
  assign vec0 = {bus0.a_out, bus0.b_out, bus0.c_out, bus0.d_out};
  assign vec1 = {bus1.a_out, bus1.b_out, bus1.c_out, bus1.d_out};
  assign all0 = {vec0, bus0.busy, bus0.done, bus0.pass, bus0.err_cnt,
                 bus0.fail_valid, bus0.fail_vec, bus0.fail_efg};
  assign all1 = {vec1, bus1.busy, bus1.done, bus1.pass, bus1.err_cnt,
                 bus1.fail_valid, bus1.fail_vec, bus1.fail_efg};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: apply the gate faults to the first nvec vectors and score them.
  function automatic void ref_sweep(input logic [2:0] s0, input logic [2:0] s1, input int nvec,
                                    output int err, output int first_vec, output int first_efg);
    err = 0;
    first_vec = -1;
    first_efg = 0;
    for (int v = 0; v < nvec; v++) begin
      int ab   = ((v >> 3) & 1) & ((v >> 2) & 1);
      int cd   = ((v >> 1) & 1) & (v & 1);
      int good = ab * 4 + cd * 2 + (ab & cd);
      int seen = ((good & ~int'(s0)) | int'(s1)) & 7;
      if (seen != good) begin
        err++;
        if (first_vec < 0) begin
          first_vec = v;
          first_efg = seen;
        end
      end
    end
  endfunction

  task automatic run_sweep(input logic [2:0] s0, input logic [2:0] s1, input int idle);
    int err0, fv, fe, d1, err1;
    @(negedge clk);
    sa0 = s0;
    sa1 = s1;
    repeat (idle) @(negedge clk);
    ref_sweep(s0, s1, 16, err0, fv, fe);
    d1   = (fv < 0) ? 48 : 3 * fv + 3;
    err1 = (fv < 0) ? 0 : 1;
    bus0.start = 1'b1;
    bus1.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      check_eq("sweep_vec0",  vec0, (k < 48) ? k / 3 : 15);
      check_eq("sweep_busy0", bus0.busy, (k < 48) ? 1 : 0);
      check_eq("sweep_done0", bus0.done, (k >= 48) ? 1 : 0);
      check_eq("sof_vec1",    vec1, (k < d1) ? k / 3 : d1 / 3 - 1);
      check_eq("sof_busy1",   bus1.busy, (k < d1) ? 1 : 0);
      check_eq("sof_done1",   bus1.done, (k >= d1) ? 1 : 0);
      if (k < 49) @(negedge clk);
    end
    $display("sweep sa0=%b sa1=%b: err=%0d first_vec=%0d efg=%0d | dut0 err=%0d fvec=%0d efg=%0d | dut1 err=%0d",
             s0, s1, err0, fv, fe, bus0.err_cnt, bus0.fail_vec, bus0.fail_efg, bus1.err_cnt);
    check_eq("sweep_err0",   bus0.err_cnt, err0);
    check_eq("sweep_pass0",  bus0.pass, (err0 == 0) ? 1 : 0);
    check_eq("sweep_fval0",  bus0.fail_valid, (fv >= 0) ? 1 : 0);
    check_eq("sweep_fvec0",  bus0.fail_vec, (fv >= 0) ? fv : 0);
    check_eq("sweep_fefg0",  bus0.fail_efg, (fv >= 0) ? fe : 0);
    check_eq("sof_err1",     bus1.err_cnt, err1);
    check_eq("sof_pass1",    bus1.pass, (err1 == 0) ? 1 : 0);
    check_eq("sof_fvec1",    bus1.fail_vec, (fv >= 0) ? fv : 0);
    check_eq("sof_fefg1",    bus1.fail_efg, (fv >= 0) ? fe : 0);
  endtask

  // Start dut0 with start held high throughout, abort at edge index abort_edge.
  task automatic run_abort(input logic [2:0] s0, input logic [2:0] s1, input int abort_edge);
    int err, fv, fe;
    @(negedge clk);
    sa0 = s0;
    sa1 = s1;
    ref_sweep(s0, s1, (abort_edge - 1) / 3, err, fv, fe);
    bus0.start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < abort_edge; k++) begin
      check_eq("abort_run_vec", vec0, k / 3);
      check_eq("abort_run_busy", bus0.busy, 1);
      if (k == abort_edge - 1) bus0.abort = 1'b1;
      @(negedge clk);
    end
    bus0.abort = 1'b0;
    bus0.start = 1'b0;
    $display("abort at edge %0d sa0=%b sa1=%b: err=%0d first_vec=%0d | dut err=%0d busy=%0d done=%0d vec=%0d",
             abort_edge, s0, s1, err, fv, bus0.err_cnt, bus0.busy, bus0.done, vec0);
    check_eq("abort_vec",   vec0, 0);
    check_eq("abort_busy",  bus0.busy, 0);
    check_eq("abort_done",  bus0.done, 0);
    check_eq("abort_err",   bus0.err_cnt, err);
    check_eq("abort_fval",  bus0.fail_valid, (fv >= 0) ? 1 : 0);
    check_eq("abort_fvec",  bus0.fail_vec, (fv >= 0) ? fv : 0);
    check_eq("abort_fefg",  bus0.fail_efg, (fv >= 0) ? fe : 0);
    @(negedge clk);
    check_eq("abort_idle_busy", bus0.busy, 0);
    check_eq("abort_idle_vec",  vec0, 0);
  endtask

  task automatic run_reset_mid(input int edges);
    @(negedge clk);
    bus0.start = 1'b1;
    bus1.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    repeat (edges) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("reset after %0d edges: dut0 outputs=0x%0h dut1 outputs=0x%0h", edges, all0, all1);
    check_eq("rst_mid_dut0", all0, 0);
    check_eq("rst_mid_dut1", all1, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus0.start = 1'b0;
    bus0.abort = 1'b0;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    #23;
    $display("reset: dut0 outputs=0x%0h dut1 outputs=0x%0h", all0, all1);
    check_eq("reset_dut0", all0, 0);
    check_eq("reset_dut1", all1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep(3'b000, 3'b000, 2);   // healthy gate
    run_sweep(3'b001, 3'b000, 1);   // g stuck-at-0
    run_sweep(3'b000, 3'b100, 0);   // e stuck-at-1
    run_abort(3'b000, 3'b100, 20);

    for (int i = 0; i < 6; i++) begin
      run_sweep(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom_range(0, 3));
    end
    for (int i = 0; i < 3; i++) begin
      run_abort(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom_range(2, 46));
    end

    run_reset_mid($urandom_range(5, 40));
    run_sweep(3'b000, 3'b000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
